// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and the memory-stage state type.
// Imported by the memory-stage FSM and its load-extension helper.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // funct3[1:0] encodes the access size: 00 byte, 01 halfword, 10 word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'b00:   is_aligned = 1'b1;
      2'b01:   is_aligned = ~addr_lo[0];
      2'b10:   is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module ld_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    byte_lane = rdata[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    data      = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stagemem.sv
// Pipeline memory stage: IDLE/REQ handshake FSM towards a data memory with
// alignment/legality checks, store lane placement, load extension and a wait-abort counter.
module stagemem
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_exc,
  output logic        o_timeout,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        legal, aligned, start, bad_access, acc_done, acc_abort;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, ext_data;

  always_comb begin
    legal = 1'b0;
    if (i_mem_rd && !i_mem_wr)
      legal = i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else if (i_mem_wr && !i_mem_rd)
      legal = i_funct3 inside {F3_SB, F3_SH, F3_SW};
    aligned    = is_aligned(i_funct3[1:0], i_alu_data[1:0]);
    start      = (state == IDLE) && i_valid && legal && aligned;
    bad_access = (state == IDLE) && i_valid && (i_mem_rd || i_mem_wr) && !(legal && aligned);
    // The abort fires in the REQ cycle that would be the WAIT_MAX-th without ack; an ack there wins.
    acc_done   = (state == REQ) && i_dmem_ack;
    acc_abort  = (state == REQ) && !i_dmem_ack && (wait_cnt == CNT_LAST);
    o_stall    = !i_rst && (start || ((state == REQ) && !i_dmem_ack));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (acc_done || acc_abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = i_rs2_data;
    case (i_funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << i_alu_data[1:0];
        wdata_nxt = {4{i_rs2_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << i_alu_data[1:0];
        wdata_nxt = {2{i_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  ld_extend u_ld_extend (
    .rdata  (i_dmem_rdata),
    .addr   (addr_lo_q),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  // NOTE: sequential state uses non-blocking assignments only; the synchronous reset has priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_ld_data    <= '0;
      o_ld_valid   <= 1'b0;
      o_exc        <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_ld_valid <= acc_done && !o_dmem_we;
      o_exc      <= bad_access;
      o_timeout  <= acc_abort;
      if (start) begin
        o_dmem_req   <= 1'b1;
        o_dmem_we    <= i_mem_wr;
        o_dmem_addr  <= {i_alu_data[31:2], 2'b00};
        o_dmem_wdata <= wdata_nxt;
        o_dmem_be    <= be_nxt;
        funct3_q     <= i_funct3;
        addr_lo_q    <= i_alu_data[1:0];
        wait_cnt     <= '0;
      end else if (acc_done || acc_abort) begin
        o_dmem_req <= 1'b0;
      end else if (state == REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (acc_done && !o_dmem_we)
        o_ld_data <= ext_data;
    end
  end

endmodule

// File: tb/tb_stagemem.sv
// Scoreboard bench for stagemem: a driver issues accesses and queues the expected
// dmem requests and responses; a monitor pops and compares as the DUT presents them.
module tb_stagemem;
  import riscv_pkg::*;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] alu_data, rs2_data;
  logic        stall, ld_valid, exc, timeout;
  logic [31:0] ld_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  stagemem #(.WAIT_MAX(WAIT_MAX)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .i_mem_rd     (mem_rd),
    .i_mem_wr     (mem_wr),
    .i_funct3     (funct3),
    .i_alu_data   (alu_data),
    .i_rs2_data   (rs2_data),
    .o_stall      (stall),
    .o_ld_data    (ld_data),
    .o_ld_valid   (ld_valid),
    .o_exc        (exc),
    .o_timeout    (timeout),
    .o_dmem_req   (dmem_req),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .o_dmem_be    (dmem_be),
    .i_dmem_ack   (dmem_ack),
    .i_dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  // kind is {ld_valid, exc, timeout}
  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit acc_ok(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    bit lg;
    if (rd == wr) return 1'b0;
    lg = rd ? (f3 != 3 && f3 != 6 && f3 != 7) : (f3 <= 2);
    sz = 1 << f3[1:0];
    return lg && ((a % sz) == 0);
  endfunction

  function automatic logic [31:0] load_val(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int sz, off;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    off = int'(a % 4);
    v = rd >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic req_t store_req(logic [2:0] f3, logic [31:0] a, logic [31:0] d, bit wr);
    req_t r;
    int sz, off;
    sz = 1 << f3[1:0];
    off = int'(a % 4);
    r.addr = a - (a % 4);
    r.we = wr;
    r.be = 4'(((1 << sz) - 1) << off);
    if (sz == 1) r.wdata = (d & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) r.wdata = (d & 32'hFFFF) * 32'h0001_0001;
    else r.wdata = d;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge. ack_delay = REQ cycles without ack before the ack
  // cycle; ack_delay >= WAIT_MAX means the memory never answers.
  task automatic do_access(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input int ack_delay,
                           input logic [31:0] rdata, output int n_stall);
    bit ok, go;
    resp_t rs;
    ok = acc_ok(rd, wr, f3, a);
    go = v && ok;
    n_stall = 0;
    valid = v; mem_rd = rd; mem_wr = wr; funct3 = f3; alu_data = a; rs2_data = d;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    if (go) begin
      req_q.push_back(store_req(f3, a, d, wr));
      if (rd) begin
        rs.kind = (ack_delay < WAIT_MAX) ? 3'b100 : 3'b001;
        rs.data = load_val(f3, a, rdata);
        resp_q.push_back(rs);
      end else if (ack_delay >= WAIT_MAX) begin
        rs.kind = 3'b001; rs.data = '0;
        resp_q.push_back(rs);
      end
    end else if (v && (rd || wr)) begin
      rs.kind = 3'b010; rs.data = '0;
      resp_q.push_back(rs);
    end
    @(negedge clk);
    check("stall_issue", 32'(stall), 32'(go));
    n_stall += int'(stall);
    @(posedge clk); #1;
    valid = 1'b0; mem_rd = 1'($urandom); mem_wr = 1'($urandom);
    funct3 = 3'($urandom); alu_data = $urandom; rs2_data = $urandom;
    if (go) begin
      for (int k = 0; k < WAIT_MAX; k++) begin
        dmem_ack = (k == ack_delay);
        dmem_rdata = dmem_ack ? rdata : $urandom;
        @(negedge clk);
        check("stall_req", 32'(stall), 32'(!dmem_ack));
        n_stall += int'(stall);
        @(posedge clk); #1;
        if (k == ack_delay) break;
      end
      dmem_ack = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic  prev_req;
    logic [31:0] last_ld;
    req_t  er;
    resp_t ep;
    prev_req = 1'b0;
    last_ld = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_ld = '0;
        prev_req = 1'b0;
      end else begin
        if (dmem_req === 1'b1 && prev_req !== 1'b1) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", 32'(dmem_req), 32'd0);
          end else begin
            er = req_q.pop_front();
            check("req_addr", dmem_addr, er.addr);
            check("req_we", 32'(dmem_we), 32'(er.we));
            if (er.we) begin
              check("req_be", 32'(dmem_be), 32'(er.be));
              check("req_wdata", dmem_wdata, er.wdata);
            end
          end
        end
        if ((ld_valid | exc | timeout) === 1'b1) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", 32'({ld_valid, exc, timeout}), 32'd0);
          end else begin
            ep = resp_q.pop_front();
            check("resp_kind", 32'({ld_valid, exc, timeout}), 32'(ep.kind));
            if (ep.kind == 3'b100) begin
              check("ld_data", ld_data, ep.data);
              last_ld = ep.data;
            end else begin
              check("ld_hold", ld_data, last_ld);
            end
          end
        end
        prev_req = dmem_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ns, sel, dly;
    bit v, rd, wr;
    logic [31:0] a;
    rst = 1'b1; valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = F3_LW;
    alu_data = 32'h0; rs2_data = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_pulses", 32'({ld_valid, exc, timeout}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;

    do_access(1, 1, 0, F3_LW, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, ns);
    check("lw_stall_cycles", 32'(ns), 32'd3);
    do_access(1, 1, 0, F3_LB, 32'h103, 32'h0, 0, 32'h8000_0000, ns);
    do_access(1, 1, 0, F3_LBU, 32'h103, 32'h0, 1, 32'h8000_0000, ns);
    do_access(1, 1, 0, F3_LHU, 32'h102, 32'h0, 0, 32'h8000_0000, ns);
    do_access(1, 0, 1, F3_SH, 32'h206, 32'h1234_ABCD, 0, 32'h0, ns);
    do_access(1, 1, 0, F3_LW, 32'h101, 32'h0, 0, 32'h0, ns);
    check("misalign_stall", 32'(ns), 32'd0);
    do_access(1, 1, 1, F3_LW, 32'h100, 32'h0, 0, 32'h0, ns);
    do_access(1, 1, 0, F3_LW, 32'h140, 32'h0, WAIT_MAX, 32'h0, ns);
    check("timeout_stall_cycles", 32'(ns), 32'(WAIT_MAX + 1));
    do_access(1, 1, 0, F3_LW, 32'h144, 32'h0, WAIT_MAX - 1, 32'h5A5A_1234, ns);
    check("late_ack_stall_cycles", 32'(ns), 32'(WAIT_MAX));

    // Reset in the 2nd REQ cycle with a simultaneous ack aborts the load.
    req_q.push_back(store_req(F3_LW, 32'h300, 32'h0, 1'b0));
    valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = F3_LW; alu_data = 32'h300;
    @(posedge clk); #1;
    valid = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D; rst = 1'b1;
    @(negedge clk);
    check("stall_in_reset", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    check("abort_req", 32'(dmem_req), 32'd0);
    check("abort_we", 32'(dmem_we), 32'd0);
    check("abort_wdata", dmem_wdata, 32'd0);
    check("abort_ld_data", ld_data, 32'd0);
    check("abort_pulses", 32'({ld_valid, exc, timeout}), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      rd = (sel <= 4) || (sel == 9);
      wr = (sel >= 5);
      v = ($urandom_range(0, 15) != 0);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      dly = ($urandom_range(0, 7) == 0) ? $urandom_range(WAIT_MAX - 2, WAIT_MAX + 1)
                                        : $urandom_range(0, 3);
      do_access(v, rd, wr, 3'($urandom), a, $urandom, dly, $urandom, ns);
    end

    valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
